// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and filters A/B/index pins and
// produces step/direction/load strobes for an up/down position counter.
module quad_step_decoder #(
  parameter int size = 8,
  parameter int FILTER_CYCLES = 4,
  parameter logic [size-1:0] INDEX_VALUE = {{(size-1){1'b0}}, 1'b1}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            quad_a,
  input  logic            quad_b,
  input  logic            quad_i,
  input  logic            index_en,
  input  logic            err_clr,
  output logic            enable,
  output logic            up_down,
  output logic [size-1:0] load,
  output logic            err
);

  typedef enum logic {PRIME, RUN} state_t;

  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic [2:0] filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 3'b000;
      sync2_reg <= 3'b000;
    end else begin
      sync1_reg <= {quad_a, quad_b, quad_i};
      sync2_reg <= sync1_reg;
    end
  end

  // Bit 2 = A, bit 1 = B, bit 0 = index.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filter
      logic       level_reg;
      logic [7:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          level_reg <= 1'b0;
          cnt_reg   <= 8'd0;
        end else if (sync2_reg[gi] != level_reg) begin
          if (cnt_reg == 8'(FILTER_CYCLES - 1)) begin
            level_reg <= sync2_reg[gi];
            cnt_reg   <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end else begin
          cnt_reg <= 8'd0;
        end
      end

      assign filt[gi] = level_reg;
    end
  endgenerate

  state_t     state_reg;
  logic [8:0] prime_cnt_reg;
  logic [1:0] prev_reg;
  logic       prev_i_reg;

  logic [1:0] cur;
  logic       step_fwd;
  logic       step_bwd;
  logic       step_bad;
  logic       index_hit;

  // Forward Gray order {a,b}: 00 -> 01 -> 11 -> 10 -> 00.
  assign cur       = filt[2:1];
  assign step_fwd  = (cur == {prev_reg[0], ~prev_reg[1]});
  assign step_bwd  = (cur == {~prev_reg[0], prev_reg[1]});
  assign step_bad  = (cur == ~prev_reg);
  assign index_hit = index_en & filt[0] & ~prev_i_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PRIME;
      prime_cnt_reg <= 9'd0;
      prev_reg      <= 2'b00;
      prev_i_reg    <= 1'b0;
      enable        <= 1'b0;
      up_down       <= 1'b0;
      load          <= '0;
      err           <= 1'b0;
    end else begin
      enable <= 1'b0;
      load   <= '0;
      if (err_clr)
        err <= 1'b0;
      case (state_reg)
        PRIME: begin
          // Wait until pin levels present at reset have passed the filter,
          // so they are absorbed into prev instead of decoded as motion.
          if (prime_cnt_reg == 9'(FILTER_CYCLES + 2)) begin
            prev_reg   <= cur;
            prev_i_reg <= filt[0];
            state_reg  <= RUN;
          end else begin
            prime_cnt_reg <= prime_cnt_reg + 9'd1;
          end
        end
        RUN: begin
          prev_reg   <= cur;
          prev_i_reg <= filt[0];
          if (step_fwd) begin
            enable  <= 1'b1;
            up_down <= 1'b1;
          end else if (step_bwd) begin
            enable  <= 1'b1;
            up_down <= 1'b0;
          end else if (step_bad) begin
            err <= 1'b1;
          end
          if (index_hit) begin
            enable <= 1'b1;
            load   <= INDEX_VALUE;
          end
        end
        default: state_reg <= PRIME;
      endcase
    end
  end

endmodule
